uart_frame_parser: RTL and testbench

//  Reader for the UART wrapper's RX side: pops received bytes and assembles them into

---
 rtl/uart_frame_pkg.sv | 23 ++
 rtl/uart_frame_buf.sv | 26 ++
 rtl/uart_frame_parser.sv | 201 ++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared constants and enums for the UART command-frame parser.
// UART_FRAME_CSUM_EN selects whether frames carry a trailing XOR checksum byte.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    PAYLOAD,
    CSUM,
    EMIT
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    BAD_LEN,
    BAD_CSUM,
    TIMEOUT
  } drop_e;

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: MAX_LEN x 8 simple dual-port payload store.
// One write port, registered read port with one cycle of latency.
module uart_frame_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    if (i_re) rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles A5/CMD/LEN/payload frames from the RX FIFO and
// replays the payload as a CMD-tagged stream. UART_FRAME_CSUM_EN adds a CSUM byte.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN     = 32,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_ready,
  output logic       o_rx_req,
  output logic [7:0] o_cmd,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last,
  output logic       o_frame_err,
  output logic [7:0] o_err_cnt
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    MAX_B    = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  state_e        post_st;
  drop_e         rsn;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d, idx_nx;
  logic [7:0]    err_cnt_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          valid_q, valid_d;
  logic          pop_q, err_q;
  logic          pop, last, drop, csum_bad;
  logic          we, re;
  logic [AW-1:0] raddr;
  logic [7:0]    rdata;

`ifdef UART_FRAME_CSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (pop) begin
      unique case (state_q)
        CMD:          csum_d = i_rx_data;
        LEN, PAYLOAD: csum_d = csum_q ^ i_rx_data;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign csum_bad = (i_rx_data != csum_q);
  assign post_st  = CSUM;
`else
  assign csum_bad = 1'b0;
  assign post_st  = EMIT;
`endif

  // FIFO ready lags a pop by one cycle, so never pop back to back
  assign pop    = i_rst && i_rx_ready && !pop_q && (state_q != EMIT);
  assign idx_nx = idx_q + 8'd1;
  assign last   = valid_q &&
                  ((len_q == 8'd0) || (idx_q == len_q - 8'd1));
  assign drop   = (rsn != NONE);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    rsn     = NONE;
    we      = 1'b0;
    re      = 1'b0;
    raddr   = idx_q[AW-1:0];
    tmo_d   = '0;

    if (!pop && (state_q inside {CMD, LEN, PAYLOAD, CSUM})) begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_q == TMO_LAST) rsn = TIMEOUT;
    end

    unique case (state_q)
      IDLE: begin
        if (pop && (i_rx_data == SYNC_BYTE)) state_d = CMD;
      end
      CMD: begin
        if (pop) begin
          cmd_d   = i_rx_data;
          state_d = LEN;
        end
      end
      LEN: begin
        if (pop) begin
          len_d = i_rx_data;
          idx_d = 8'd0;
          if (i_rx_data > MAX_B) rsn = BAD_LEN;
          else if (i_rx_data == 8'd0) state_d = post_st;
          else state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pop) begin
          we    = 1'b1;
          idx_d = idx_nx;
          if (idx_q == len_q - 8'd1) begin
            idx_d   = 8'd0;
            state_d = post_st;
          end
        end
      end
      CSUM: begin
        if (pop) begin
          if (csum_bad) rsn = BAD_CSUM;
          else state_d = EMIT;
        end
      end
      EMIT: begin
        if (!valid_q) begin
          re      = 1'b1;
          valid_d = 1'b1;
        end else if (i_ready) begin
          if (last) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d = idx_nx;
            re    = 1'b1;
            raddr = idx_nx[AW-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (drop) state_d = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      valid_q   <= 1'b0;
      pop_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      pop_q   <= pop;
      err_q   <= drop;
      if (drop && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      assert (!(pop_q && pop));
      if (rsn == BAD_CSUM) assert (state_q == CSUM);
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .i_clk   (i_clk),
    .i_we    (we),
    .i_waddr (idx_q[AW-1:0]),
    .i_wdata (i_rx_data),
    .i_re    (re),
    .i_raddr (raddr),
    .o_rdata (rdata)
  );

  assign o_rx_req    = pop;
  assign o_cmd       = cmd_q;
  assign o_data      = (valid_q && (len_q != 8'd0)) ? rdata : 8'h00;
  assign o_valid     = valid_q;
  assign o_last      = last;
  assign o_frame_err = err_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed vectors, timeout/stall/reset sequences and
// random frame streams checked against a byte-stream parsing model.
module tb_uart_frame_parser;

  localparam int MAXL = 8;
  localparam int TMO  = 200;
`ifdef UART_FRAME_CSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_req;
  logic [7:0] cmd, data, ecnt;
  logic       valid, last, ferr;
  logic       rdy = 1'b0;

  always #5 clk = ~clk;

  uart_frame_parser #(
    .MAX_LEN     (MAXL),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_ready  (rx_ready),
    .o_rx_req    (rx_req),
    .o_cmd       (cmd),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (rdy),
    .o_last      (last),
    .o_frame_err (ferr),
    .o_err_cnt   (ecnt)
  );

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    int          njunk;
    logic [7:0]  cmd;
    logic [7:0]  len;
    logic [63:0] pl;
    bit          bad;
    int          exp_beats;
    int          exp_err;
  } vec_t;

  logic [7:0] rxq[$];
  logic [7:0] stim[$];
  beat_t      got[$];
  int checks = 0, failures = 0, errs = 0, ncyc = 0, exp_cnt = 0;
  int last_pop_cyc = 0, err_cyc = 0;
  bit lag = 0, hold_rand = 0, rdy_rand = 0, rdy_val = 1;
  logic prev_v = 0, prev_r = 0;
  logic [7:0] prev_d = 0;

  task automatic chk(input string nm, input logic [31:0] g,
                     input logic [31:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, g, e);
    end
  endtask

  // one clock: drive at negedge, sample 1ns later, far from posedge
  task automatic cyc();
    @(negedge clk);
    rx_ready = lag ? 1'b1 :
               ((rxq.size() > 0) && !(hold_rand && ($urandom_range(0, 3) == 0)));
    rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
    rdy      = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    #1;
    ncyc++;
    if (lag) chk("rx_req_b2b", 32'(rx_req), 0);
    if (valid) chk("rx_req_in_emit", 32'(rx_req), 0);
    if (prev_v && !prev_r) begin
      chk("stall_valid", 32'(valid), 1);
      chk("stall_data", 32'(data), 32'(prev_d));
    end
    if (rx_req && (rxq.size() > 0)) begin
      void'(rxq.pop_front());
      last_pop_cyc = ncyc;
    end
    if (valid && rdy) got.push_back(beat_t'{cmd, data, last});
    if (ferr) begin
      errs++;
      err_cyc = ncyc;
    end
    lag    = rx_req;
    prev_v = valid;
    prev_r = rdy;
    prev_d = data;
  endtask

  task automatic run_idle(input string nm);
    int quiet = 0;
    for (int k = 0; k < 4000; k++) begin
      cyc();
      if ((rxq.size() == 0) && !valid && !rx_req) quiet++;
      else quiet = 0;
      if (quiet >= 8) return;
    end
    chk({nm, "_drain_timeout"}, 1, 0);
  endtask

  task automatic put_frame(input logic [7:0] c, input logic [7:0] l,
                           input logic [7:0] pl[$], input bit bad);
    logic [7:0] x;
    stim.push_back(8'hA5);
    stim.push_back(c);
    stim.push_back(l);
    x = c ^ l;
    foreach (pl[k]) begin
      stim.push_back(pl[k]);
      x ^= pl[k];
    end
    if (CS && (int'(l) <= MAXL)) stim.push_back(bad ? (x ^ 8'h5A) : x);
  endtask

  task automatic load();
    foreach (stim[k]) rxq.push_back(stim[k]);
  endtask

  // reference: scan the byte stream for whole frames
  task automatic model(input logic [7:0] s[$], output beat_t eb[$],
                       output int ne);
    int i, n;
    logic [7:0] c, l, x;
    eb.delete();
    ne = 0;
    i  = 0;
    while (i < s.size()) begin
      if ((s[i] != 8'hA5) || (i + 2 >= s.size())) begin
        i++;
        continue;
      end
      c = s[i+1];
      l = s[i+2];
      i += 3;
      if (int'(l) > MAXL) begin
        ne++;
        continue;
      end
      n = int'(l) + (CS ? 1 : 0);
      if (i + n > s.size()) break;
      x = c ^ l;
      for (int k = 0; k < int'(l); k++) x ^= s[i+k];
      if (CS && (s[i+int'(l)] != x)) ne++;
      else if (l == 8'd0) eb.push_back(beat_t'{c, 8'h00, 1'b1});
      else
        for (int k = 0; k < int'(l); k++)
          eb.push_back(beat_t'{c, s[i+k], (k == int'(l) - 1)});
      i += n;
    end
  endtask

  task automatic cmp_beats(input string nm, input beat_t ex[$],
                           input int exp_err);
    chk({nm, "_nbeats"}, got.size(), ex.size());
    for (int k = 0; (k < ex.size()) && (k < got.size()); k++)
      chk({nm, "_beat"}, 32'(got[k]), 32'(ex[k]));
    chk({nm, "_errs"}, errs, exp_err);
    exp_cnt = (exp_cnt + exp_err > 255) ? 255 : exp_cnt + exp_err;
    chk({nm, "_errcnt"}, 32'(ecnt), exp_cnt);
    got.delete();
    errs = 0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_rx_req"}, 32'(rx_req), 0);
    chk({nm, "_valid"}, 32'(valid), 0);
    chk({nm, "_last"}, 32'(last), 0);
    chk({nm, "_ferr"}, 32'(ferr), 0);
    chk({nm, "_cmd"}, 32'(cmd), 0);
    chk({nm, "_data"}, 32'(data), 0);
    chk({nm, "_errcnt"}, 32'(ecnt), 0);
  endtask

  initial begin
    vec_t       tv[6];
    beat_t      eb[$];
    logic [7:0] pl[$];
    logic [7:0] c, l, b;
    int         ne, n2, d;

    tv[0] = '{0, 8'h10, 8'd3, 64'h0000_0000_0033_2211, 1'b0, 3, 0};
    tv[1] = '{0, 8'h10, 8'd3, 64'h0000_0000_0033_2211, 1'b1,
              CS ? 0 : 3, CS ? 1 : 0};
    tv[2] = '{2, 8'h20, 8'd0, 64'h0, 1'b0, 1, 0};
    tv[3] = '{0, 8'h44, 8'(MAXL + 1), 64'h0, 1'b0, 0, 1};
    tv[4] = '{0, 8'h55, 8'(MAXL), 64'h0706_0504_0302_01A5, 1'b0, MAXL, 0};
    tv[5] = '{1, 8'h66, 8'd1, 64'h0000_0000_0000_00A5, 1'b0, 1, 0};

    rst_n = 1'b0;
    cyc();
    cyc();
    chk_reset("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      stim.delete();
      pl.delete();
      for (int j = 0; j < tv[v].njunk; j++) stim.push_back(j[0] ? 8'hFF : 8'h00);
      if (int'(tv[v].len) <= MAXL)
        for (int k = 0; k < int'(tv[v].len); k++) pl.push_back(tv[v].pl[8*k +: 8]);
      put_frame(tv[v].cmd, tv[v].len, pl, tv[v].bad);
      load();
      run_idle("vec");
      eb.delete();
      for (int k = 0; k < tv[v].exp_beats; k++)
        eb.push_back(beat_t'{tv[v].cmd,
                             (tv[v].len == 8'd0) ? 8'h00 : tv[v].pl[8*k +: 8],
                             (k == tv[v].exp_beats - 1)});
      cmp_beats($sformatf("vec%0d", v), eb, tv[v].exp_err);
    end

    // stall mid-frame until the inter-byte timeout fires
    stim = '{8'hA5, 8'h30, 8'h02, 8'hAA};
    load();
    for (int k = 0; k < TMO + 30; k++) cyc();
    d = err_cyc - last_pop_cyc;
    chk("tmo_delay_ok", 32'((d >= TMO) && (d <= TMO + 2)), 1);
    eb.delete();
    cmp_beats("tmo", eb, 1);
    stim.delete();
    pl = '{8'h55};
    put_frame(8'h30, 8'h01, pl, 1'b0);
    load();
    run_idle("tmo_next");
    eb = '{beat_t'{8'h30, 8'h55, 1'b1}};
    cmp_beats("tmo_next", eb, 0);

    // downstream stall in EMIT with the next frame already queued
    rdy_val = 1'b0;
    stim.delete();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    put_frame(8'h77, 8'h04, pl, 1'b0);
    n2 = stim.size();
    pl = '{8'hA5, 8'h9C};
    put_frame(8'h78, 8'h02, pl, 1'b0);
    n2 = stim.size() - n2;
    load();
    for (int k = 0; (k < 200) && !valid; k++) cyc();
    chk("stall_reach", 32'(valid), 1);
    repeat (10) cyc();
    chk("stall_hold_data", 32'(data), 32'h01);
    chk("stall_no_pop", rxq.size(), n2);
    rdy_val = 1'b1;
    run_idle("stall");
    model(stim, eb, ne);
    cmp_beats("stall", eb, ne);

    // reset in the middle of a payload
    stim = '{8'hA5, 8'h40, 8'h05, 8'h01, 8'h02};
    load();
    for (int k = 0; (k < 100) && (rxq.size() > 0); k++) cyc();
    repeat (3) cyc();
    rst_n = 1'b0;
    rxq.delete();
    cyc();
    cyc();
    chk_reset("midrst");
    rst_n = 1'b1;
    got.delete();
    errs    = 0;
    exp_cnt = 0;
    stim.delete();
    pl = '{8'hC3, 8'hD4};
    put_frame(8'h41, 8'h02, pl, 1'b0);
    load();
    run_idle("postrst");
    model(stim, eb, ne);
    cmp_beats("postrst", eb, ne);

    // random frame streams with FIFO gaps and downstream backpressure
    hold_rand = 1'b1;
    rdy_rand  = 1'b1;
    for (int it = 0; it < 12; it++) begin
      stim.delete();
      repeat ($urandom_range(3, 6)) begin
        repeat ($urandom_range(0, 2)) begin
          b = 8'($urandom);
          stim.push_back((b == 8'hA5) ? 8'h00 : b);
        end
        c = 8'($urandom);
        l = ($urandom_range(0, 9) == 0) ? 8'(MAXL + 1 + $urandom_range(0, 20))
                                         : 8'($urandom_range(0, MAXL));
        pl.delete();
        if (int'(l) <= MAXL)
          for (int k = 0; k < int'(l); k++) pl.push_back(8'($urandom));
        put_frame(c, l, pl, ($urandom_range(0, 4) == 0));
      end
      load();
      model(stim, eb, ne);
      run_idle("rand");
      cmp_beats($sformatf("rand%0d", it), eb, ne);
    end
    hold_rand = 1'b0;
    rdy_rand  = 1'b0;
    rdy_val   = 1'b1;

    // error counter saturation
    stim.delete();
    repeat (260) begin
      stim.push_back(8'hA5);
      stim.push_back(8'h00);
      stim.push_back(8'hFF);
    end
    load();
    run_idle("sat");
    eb.delete();
    cmp_beats("sat", eb, 260);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
